// File: rtl/opll_sched_pkg.sv
// rtl/opll_sched_pkg.sv - shared types and timing defaults for the OPLL write scheduler
package opll_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_PULSE,
        A_WAIT,
        D_PULSE,
        D_WAIT
    } sched_state_t;

    localparam int OPLL_ADDR_WAIT = 12;
    localparam int OPLL_DATA_WAIT = 84;
    localparam int OPLL_WR_PULSE  = 2;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } opll_cmd_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/opll_write_scheduler_if.sv
// rtl/opll_write_scheduler_if.sv - host request and OPLL pin-bus bundle
interface opll_write_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_addr;
    logic [7:0]    req_data;
    logic          hold;
    logic [7:0]    o_D;
    logic          o_A0;
    logic          o_WR_n;
    logic          o_CS_n;
    logic          busy;
    logic [LW-1:0] fifo_level;

    modport master (
        output req_valid, req_addr, req_data, hold,
        input  req_ready, o_D, o_A0, o_WR_n, o_CS_n, busy, fifo_level
    );

    modport slave (
        input  req_valid, req_addr, req_data, hold,
        output req_ready, o_D, o_A0, o_WR_n, o_CS_n, busy, fifo_level
    );

endinterface

// File: rtl/opll_cmd_fifo.sv
// rtl/opll_cmd_fifo.sv - synchronous command FIFO, no bypass, async reset
module opll_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/opll_write_scheduler.sv
// rtl/opll_write_scheduler.sv - queues host writes and replays them on the OPLL bus with chip wait times
module opll_write_scheduler
    import opll_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_PULSE   = OPLL_WR_PULSE,
    parameter int ADDR_WAIT  = OPLL_ADDR_WAIT,
    parameter int DATA_WAIT  = OPLL_DATA_WAIT
) (
    input  logic                   clk,
    input  logic                   rst,
    opll_write_scheduler_if.slave  bus
);
    localparam int LW   = $clog2(FIFO_DEPTH + 1);
    localparam int CMAX = max3(WR_PULSE, ADDR_WAIT, DATA_WAIT);
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] CNT_WR = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] CNT_AW = CW'(ADDR_WAIT - 1);
    localparam logic [CW-1:0] CNT_DW = CW'(DATA_WAIT - 1);

    sched_state_t  state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pop;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic [15:0]   head_raw;
    opll_cmd_t     head;
    opll_cmd_t     cur;

    logic [7:0]    d_q, d_n;
    logic          a0_q, a0_n;
    logic          wr_n_q, wr_n_n;
    logic          cs_n_q, cs_n_n;

    opll_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(opll_cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req_valid && bus.req_ready),
        .wdata ({bus.req_addr, bus.req_data}),
        .pop   (pop),
        .rdata (head_raw),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign head = head_raw;

    // Ready is held low for the whole reset window, independent of FIFO state.
    assign bus.req_ready  = !rst && !full;
    assign bus.fifo_level = level;
    assign bus.busy       = (state != IDLE) || !empty;
    assign bus.o_D        = d_q;
    assign bus.o_A0       = a0_q;
    assign bus.o_WR_n     = wr_n_q;
    assign bus.o_CS_n     = cs_n_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.hold) begin
                    pop     = 1'b1;
                    state_n = A_PULSE;
                    cnt_n   = CNT_WR;
                end
            end
            A_PULSE: begin
                if (cnt == '0) begin
                    state_n = A_WAIT;
                    cnt_n   = CNT_AW;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            A_WAIT: begin
                if (cnt == '0) begin
                    state_n = D_PULSE;
                    cnt_n   = CNT_WR;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            D_PULSE: begin
                if (cnt == '0) begin
                    state_n = D_WAIT;
                    cnt_n   = CNT_DW;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            D_WAIT: begin
                if (cnt == '0) begin
                    // Chain straight into the next address pulse to keep the write period constant.
                    if (!empty && !bus.hold) begin
                        pop     = 1'b1;
                        state_n = A_PULSE;
                        cnt_n   = CNT_WR;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bus values are computed for the state being entered so the pins are registered.
    always_comb begin
        d_n    = d_q;
        a0_n   = a0_q;
        wr_n_n = 1'b1;
        cs_n_n = 1'b1;
        case (state_n)
            A_PULSE: begin
                cs_n_n = 1'b0;
                wr_n_n = 1'b0;
                a0_n   = 1'b0;
                d_n    = pop ? head.addr : cur.addr;
            end
            D_PULSE: begin
                cs_n_n = 1'b0;
                wr_n_n = 1'b0;
                a0_n   = 1'b1;
                d_n    = cur.data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            cur    <= '0;
            d_q    <= '0;
            a0_q   <= 1'b0;
            wr_n_q <= 1'b1;
            cs_n_q <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            if (pop) cur <= head;
            d_q    <= d_n;
            a0_q   <= a0_n;
            wr_n_q <= wr_n_n;
            cs_n_q <= cs_n_n;
        end
    end

endmodule

// File: doc/opll_write_scheduler.md
Name: opll_write_scheduler

Overview:
Sequences CPU/host register writes into the OPLL core bus (A0, WR_n, CS_n, D) while meeting the chip's address-to-data and data-to-next-write wait times. Host-side writes are queued in a small command FIFO, and a timing FSM replays each queued write as an address phase followed by a data phase. It sits between the pin-level host interface and the IKAOPLL instance, replacing direct pin-to-bus wiring, so hosts may write faster than the chip accepts.

Parameters:
FIFO_DEPTH, 4, number of queued (addr,data) commands; power of two, at least 2
WR_PULSE, 2, cycles WR_n/CS_n held low per phase; at least 1
ADDR_WAIT, 12, idle cycles after address-pulse end before data pulse; at least 1
DATA_WAIT, 84, idle cycles after data-pulse end before next address pulse; at least 1

Ports:
clk  in  1  system clock (same clock as the OPLL emulation clock)
rst  in  1  asynchronous reset, active-high
req_valid  in  1  host offers a write command
req_ready  out  1  FIFO can accept; transfer when valid&&ready
req_addr  in  8  OPLL register address
req_data  in  8  OPLL register data
hold  in  1  when high, no new transaction starts; the in-flight one completes
o_D  out  8  data bus to OPLL i_D
o_A0  out  1  to OPLL i_A0 (0 = address, 1 = data)
o_WR_n  out  1  to OPLL i_WR_n
o_CS_n  out  1  to OPLL i_CS_n
busy  out  1  high when state != IDLE or FIFO non-empty
fifo_level  out  clog2(FIFO_DEPTH+1)  queued command count

Behaviour:
- Reset values (async, rst=1): state IDLE, FIFO empty, fifo_level=0, req_ready=0 while rst is high and 1 after release, o_D=0, o_A0=0, o_WR_n=1, o_CS_n=1, busy=0.
- All bus outputs are registered and change only on clk rising edges.
- FIFO push: on req_valid&&req_ready. req_ready=!full; there is no same-cycle pop bypass, so a full FIFO refuses a push even in a pop cycle.
- Simultaneous push and pop leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty and !hold, pop the head on this edge, go to A_PULSE, and load cnt=WR_PULSE-1.
  - A_PULSE: o_CS_n=0, o_WR_n=0, o_A0=0, o_D=addr. When cnt==0, go to A_WAIT with cnt=ADDR_WAIT-1; otherwise cnt-1.
  - A_WAIT: o_CS_n=1, o_WR_n=1, o_A0 and o_D held. When cnt==0, go to D_PULSE with cnt=WR_PULSE-1.
  - D_PULSE: o_CS_n=0, o_WR_n=0, o_A0=1, o_D=data. When cnt==0, go to D_WAIT with cnt=DATA_WAIT-1.
  - D_WAIT: strobes high, o_A0 and o_D held. When cnt==0:
    - if FIFO non-empty and !hold, pop and go directly to A_PULSE with no IDLE cycle;
    - otherwise go to IDLE.
- Latency: a push at edge k into an empty FIFO while in IDLE makes the entry visible at k+1. The pop happens at edge k+1, so A_PULSE outputs appear after edge k+1 (1 idle cycle of latency).
- One transaction takes exactly 2*WR_PULSE+ADDR_WAIT+DATA_WAIT cycles (default 100). Back-to-back transactions have the same period.
- The popped addr/data are latched into a holding register. The FIFO slot frees at pop, so req_ready can rise during a transaction.
- hold is sampled only at IDLE or at the D_WAIT exit. Asserting hold mid-transaction has no effect on that transaction.
- cnt width is clog2(max(WR_PULSE,ADDR_WAIT,DATA_WAIT)). Parameters of 1 give single-cycle phases.
- Reset asserted mid-pulse: o_WR_n and o_CS_n return to 1 immediately (async), the FIFO is flushed, and the in-flight write is lost. This is intended, because the OPLL reset shares the source.

Decomposition:
- Package opll_sched_pkg:
  - state enum (IDLE, A_PULSE, A_WAIT, D_PULSE, D_WAIT);
  - default timing constants OPLL_ADDR_WAIT=12, OPLL_DATA_WAIT=84, OPLL_WR_PULSE=2;
  - 16-bit command struct {addr[7:0], data[7:0]}.
- One sub-module, opll_cmd_fifo: a synchronous FIFO with parameterised depth and width, async active-high reset, full/empty/level outputs, and no bypass.
- The FSM, counter and holding register stay in opll_write_scheduler.

Test Plan:
- Single write addr=0x10 data=0x5A from reset:
  - address phase: o_WR_n low for 2 cycles with o_A0=0, o_D=0x10;
  - data phase: 12 cycles later, o_WR_n low for 2 cycles with o_A0=1, o_D=0x5A;
  - busy drops exactly 84 cycles after the data-pulse end.
- Burst of 3 writes pushed on consecutive cycles: all accepted (fifo_level peaks at 2); address pulses start exactly 100 cycles apart with no IDLE cycle between; data values are in order.
- Push 6 commands continuously with FIFO_DEPTH=4:
  - req_ready falls when fifo_level=4 (FIFO full);
  - the stalled command is accepted only after the next pop;
  - all 6 writes appear in order, none dropped or duplicated.
- Assert hold during D_PULSE of write 1 with write 2 queued: write 1 completes normally, FSM enters IDLE, and write 2 starts 1 cycle after hold deasserts.
- Assert rst during the A_WAIT of a write with 2 queued:
  - the same cycle, o_WR_n=1, o_CS_n=1, fifo_level=0, busy=0;
  - after release, no bus activity until a new push.
- Parameter set WR_PULSE=1, ADDR_WAIT=1, DATA_WAIT=1: each write takes 4 cycles; counter wrap and back-to-back chaining behave correctly.
